// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty flags,
// registered read data with valid strobe, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] wdata,
   input  logic              winc,
   input  logic              rinc,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              wfull,
   output logic              rempty,
   output logic              walmost_full,
   output logic              ralmost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] AF_THRESH = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_THRESH = AE_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic              wr_en;
   logic              rd_en;

   // Status is a pure function of the registered pointers; the extra wrap bit
   // distinguishes a full buffer from an empty one when the low bits match.
   assign count         = wptr - rptr;
   assign rempty        = (wptr == rptr);
   assign wfull         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
   assign walmost_full  = (count >= AF_THRESH);
   assign ralmost_empty = (count <= AE_THRESH);

   assign wr_en = winc && !wfull;
   assign rd_en = rinc && !rempty;

   always_ff @(posedge clk) begin
      if (!flush && wr_en) begin
         mem[wptr[ADDR_W-1:0]] <= wdata;
      end
   end

   // Flush outranks any request in the same cycle and raises no error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wptr      <= '0;
         rptr      <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_en) begin
            rdata <= mem[rptr[ADDR_W-1:0]];
            rptr  <= rptr + PTR_ONE;
         end
         rvalid <= rd_en;
         if (winc && wfull) begin
            overflow <= 1'b1;
         end
         if (rinc && rempty) begin
            underflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters (16 x 8 bits).
module tb_sync_fifo_param;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [7:0] wdata;
   logic       winc;
   logic       rinc;
   logic [7:0] rdata;
   logic       rvalid;
   logic       wfull;
   logic       rempty;
   logic       walmost_full;
   logic       ralmost_empty;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int total;
   int bad;

   sync_fifo_param #(
      .DATA_W  (8),
      .ADDR_W  (4),
      .AF_LEVEL(12),
      .AE_LEVEL(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wdata        (wdata),
      .winc         (winc),
      .rinc         (rinc),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .wfull        (wfull),
      .rempty       (rempty),
      .walmost_full (walmost_full),
      .ralmost_empty(ralmost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] d, input logic f);
      winc  = w;
      rinc  = r;
      wdata = d;
      flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      winc  = 1'b0;
      rinc  = 1'b0;
      wdata = 8'h00;

      // reset state
      apply_stimulus(0, 0, 8'h00, 0);
      apply_stimulus(0, 0, 8'h00, 0);
      check_output("rst_rempty", 32'(rempty), 1);
      check_output("rst_wfull", 32'(wfull), 0);
      check_output("rst_count", 32'(count), 0);
      check_output("rst_rvalid", 32'(rvalid), 0);
      check_output("rst_overflow", 32'(overflow), 0);
      check_output("rst_underflow", 32'(underflow), 0);
      check_output("rst_ae", 32'(ralmost_empty), 1);
      check_output("rst_af", 32'(walmost_full), 0);
      check_output("rst_rdata", 32'(rdata), 0);
      rst_n = 1'b1;
      apply_stimulus(0, 0, 8'h00, 0);

      // fill with 5*i
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus(1, 0, 8'(5 * i), 0);
         check_output("fill_count", 32'(count), i);
         check_output("fill_af", 32'(walmost_full), 32'(i >= 12));
         check_output("fill_full", 32'(wfull), 32'(i == 16));
      end

      // write while full is rejected
      apply_stimulus(1, 0, 8'hAA, 0);
      check_output("ovf_flag", 32'(overflow), 1);
      check_output("ovf_count", 32'(count), 16);
      check_output("ovf_full", 32'(wfull), 1);

      // drain in order, one cycle latency
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus(0, 1, 8'h00, 0);
         check_output("drain_rvalid", 32'(rvalid), 1);
         check_output("drain_rdata", 32'(rdata), 5 * i);
         check_output("drain_count", 32'(count), 16 - i);
         check_output("drain_ae", 32'(ralmost_empty), 32'((16 - i) <= 2));
      end
      apply_stimulus(0, 0, 8'h00, 0);
      check_output("idle_rvalid", 32'(rvalid), 0);
      check_output("idle_rdata_hold", 32'(rdata), 8'd80);
      check_output("idle_rempty", 32'(rempty), 1);
      check_output("ovf_sticky", 32'(overflow), 1);

      // simultaneous write/read while empty
      apply_stimulus(1, 1, 8'h33, 0);
      check_output("se_count", 32'(count), 1);
      check_output("se_underflow", 32'(underflow), 1);
      check_output("se_rvalid", 32'(rvalid), 0);
      apply_stimulus(0, 1, 8'h00, 0);
      check_output("se_rdata", 32'(rdata), 8'h33);
      check_output("se_rvalid2", 32'(rvalid), 1);
      check_output("se_count2", 32'(count), 0);

      // hold 8 entries, then stream across the pointer wrap
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1, 0, 8'(i), 0);
      end
      check_output("wrap_pre_count", 32'(count), 8);
      for (int k = 0; k < 40; k++) begin
         apply_stimulus(1, 1, 8'(k + 8), 0);
         check_output("wrap_rdata", 32'(rdata), k);
         check_output("wrap_rvalid", 32'(rvalid), 1);
         check_output("wrap_count", 32'(count), 8);
      end

      // bring occupancy down to 5, then flush with requests present
      for (int k = 40; k < 43; k++) begin
         apply_stimulus(0, 1, 8'h00, 0);
         check_output("pre_flush_rdata", 32'(rdata), k);
      end
      check_output("pre_flush_count", 32'(count), 5);
      check_output("pre_flush_ovf", 32'(overflow), 1);
      apply_stimulus(1, 1, 8'h99, 1);
      check_output("flush_count", 32'(count), 0);
      check_output("flush_rempty", 32'(rempty), 1);
      check_output("flush_ovf", 32'(overflow), 0);
      check_output("flush_udf", 32'(underflow), 0);
      check_output("flush_rvalid", 32'(rvalid), 0);
      check_output("flush_rdata_hold", 32'(rdata), 8'd42);
      flush = 1'b0;

      // pointers restart from zero after flush
      apply_stimulus(1, 0, 8'h11, 0);
      apply_stimulus(1, 0, 8'h22, 0);
      apply_stimulus(0, 1, 8'h00, 0);
      check_output("post_flush_rdata", 32'(rdata), 8'h11);
      check_output("post_flush_rvalid", 32'(rvalid), 1);
      rinc = 1'b0;

      // async reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check_output("arst_count", 32'(count), 0);
      check_output("arst_rempty", 32'(rempty), 1);
      check_output("arst_rdata", 32'(rdata), 0);
      check_output("arst_rvalid", 32'(rvalid), 0);
      #2;
      rst_n = 1'b1;
      apply_stimulus(1, 0, 8'h5C, 0);
      apply_stimulus(0, 1, 8'h00, 0);
      check_output("arst_after_rdata", 32'(rdata), 8'h5C);
      check_output("arst_after_count", 32'(count), 0);
      apply_stimulus(0, 0, 8'h00, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
